// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - DMEM responder shared constants: region nibbles, MMIO offsets, bit positions
// Region decode helper used by the top-level address decoder.
package dmem_pkg;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'h1;

  localparam logic [7:0] OFF_GPIO   = 8'h00;
  localparam logic [7:0] OFF_CYCLE  = 8'h04;
  localparam logic [7:0] OFF_CMP    = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_CTRL   = 8'h10;

  localparam int STATUS_PEND_BIT = 0;
  localparam int CTRL_EN_BIT     = 0;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_MMIO = 2'd2
  } region_e;

  function automatic region_e decode_region(input logic [3:0] nib);
    if (nib == REGION_RAM)  return SEL_RAM;
    if (nib == REGION_MMIO) return SEL_MMIO;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - core DMEM bus: address, write data, read/write strobes, read data
// master = core side, slave = responder side.
interface dmem_if #(
  parameter int address_size = 32
);
  logic [address_size-1:0] daddr;
  logic [address_size-1:0] ddata_w;
  logic [address_size-1:0] ddata_r;
  logic                    MemRead;
  logic                    MemWrite;

  modport master (output daddr, output ddata_w, output MemRead, output MemWrite, input ddata_r);
  modport slave  (input daddr, input ddata_w, input MemRead, input MemWrite, output ddata_r);
endinterface

// File: rtl/dmem_mmio_regs.sv
// rtl/dmem_mmio_regs.sv - GPIO, free-running CYCLE and compare timer registers with read mux
// Timer (CMP/STATUS/CTRL, irq) present only when DMEM_MMIO_TIMER_EN is defined.
module dmem_mmio_regs
  import dmem_pkg::*;
#(
  parameter int address_size = 32
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    sel,
  input  logic [7:0]              off,
  input  logic                    we,
  input  logic [address_size-1:0] wdata,
  output logic [address_size-1:0] rdata,
  output logic [address_size-1:0] gpio_out,
  output logic                    irq
);

  logic [address_size-1:0] gpio_q;
  logic [address_size-1:0] cycle;
  logic                    gpio_we;

  assign gpio_we  = sel && we && (off == OFF_GPIO);
  assign gpio_out = gpio_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gpio_q <= '0;
      cycle  <= '0;
    end else begin
      cycle <= cycle + address_size'(1);
      if (gpio_we) gpio_q <= wdata;
    end
  end

`ifdef DMEM_MMIO_TIMER_EN
  logic [address_size-1:0] cmp_q;
  logic                    en_q;
  logic                    pend_q;
  logic                    match;
  logic                    w1c;

  assign match = en_q && (cycle == cmp_q);
  assign w1c   = sel && we && (off == OFF_STATUS) && wdata[STATUS_PEND_BIT];

  // A match on the same edge as a W1C keeps the pending bit set.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cmp_q  <= '0;
      en_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (sel && we && (off == OFF_CMP))  cmp_q <= wdata;
      if (sel && we && (off == OFF_CTRL)) en_q  <= wdata[CTRL_EN_BIT];
      pend_q <= match | (pend_q & ~w1c);
    end
  end

  assign irq = pend_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_GPIO:   rdata = gpio_q;
        OFF_CYCLE:  rdata = cycle;
`ifdef DMEM_MMIO_TIMER_EN
        OFF_CMP:    rdata = cmp_q;
        OFF_STATUS: rdata[STATUS_PEND_BIT] = pend_q;
        OFF_CTRL:   rdata[CTRL_EN_BIT] = en_q;
`endif
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - DMEM responder: word RAM plus MMIO region decode, zero-latency reads
// Optional compare timer in the MMIO block is enabled by DMEM_MMIO_TIMER_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int data_size    = 1024,
  parameter int address_size = 32
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  dmem_if.slave                   bus,
  output logic [address_size-1:0] gpio_out,
  output logic                    irq
);

  localparam int IDX_W = $clog2(data_size);

  logic [address_size-1:0] mem [data_size];
  logic [IDX_W-1:0]        idx;
  region_e                 region;
  logic                    ram_we;
  logic                    mmio_sel;
  logic [7:0]              mmio_off;
  logic [address_size-1:0] mmio_rdata;
  logic [address_size-1:0] rd_word;

  // Bits above the RAM index inside a region alias; byte lane bits are ignored.
  wire unused_addr = &{1'b0, bus.daddr[address_size-5:IDX_W+2], bus.daddr[1:0]};

  assign idx      = bus.daddr[IDX_W+1:2];
  assign region   = decode_region(bus.daddr[address_size-1 -: 4]);
  assign mmio_sel = (region == SEL_MMIO);
  assign mmio_off = {bus.daddr[7:2], 2'b00};

  // A write pending while reset is held must not reach the array.
  assign ram_we = bus.MemWrite && (region == SEL_RAM) && RESET_N;

  always_ff @(posedge CLK) begin
    if (ram_we) mem[idx] <= bus.ddata_w;
  end

  dmem_mmio_regs #(
    .address_size (address_size)
  ) u_regs (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .sel      (mmio_sel),
    .off      (mmio_off),
    .we       (bus.MemWrite),
    .wdata    (bus.ddata_w),
    .rdata    (mmio_rdata),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always_comb begin
    rd_word = '0;
    case (region)
      SEL_RAM:  rd_word = mem[idx];
      SEL_MMIO: rd_word = mmio_rdata;
      default:  rd_word = '0;
    endcase
  end

  assign bus.ddata_r = bus.MemRead ? rd_word : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (vector table, directed, random)
module tb_dmem_responder;

`ifdef DMEM_MMIO_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        CLK;
  logic        RESET_N;
  logic [31:0] gpio_out;
  logic        irq;

  dmem_if dbus();

  dmem_responder #(.data_size(1024), .address_size(32)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .bus      (dbus),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state, kept as the programmer-visible register map.
  logic [31:0] m_ram [int];
  logic [31:0] m_gpio, m_cycle, m_cmp;
  bit          m_en, m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gpio = 0; m_cycle = 0; m_cmp = 0; m_en = 0; m_pend = 0;
  endtask

  function automatic int ram_key(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input bit rd);
    logic [7:0] off;
    if (!rd) return 32'h0;
    off = {a[7:2], 2'b00};
    if (a[31:28] == 4'h0) return m_ram.exists(ram_key(a)) ? m_ram[ram_key(a)] : 32'h0;
    if (a[31:28] != 4'h1) return 32'h0;
    case (off)
      8'h00: return m_gpio;
      8'h04: return m_cycle;
      8'h08: return TIMER_EN ? m_cmp : 32'h0;
      8'h0C: return TIMER_EN ? {31'h0, m_pend} : 32'h0;
      8'h10: return TIMER_EN ? {31'h0, m_en} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input bit wr);
    bit hit;
    logic [7:0] off;
    off = {a[7:2], 2'b00};
    hit = TIMER_EN && m_en && (m_cycle == m_cmp);
    if (wr) begin
      if (a[31:28] == 4'h0) m_ram[ram_key(a)] = wd;
      else if (a[31:28] == 4'h1) begin
        case (off)
          8'h00: m_gpio = wd;
          8'h08: if (TIMER_EN) m_cmp = wd;
          8'h0C: if (TIMER_EN && wd[0]) m_pend = 0;
          8'h10: if (TIMER_EN) m_en = wd[0];
          default: ;
        endcase
      end
    end
    if (hit) m_pend = 1;
    m_cycle = m_cycle + 1;
  endtask

  // One bus cycle: drive at negedge, sample read data before the edge, commit at posedge.
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                     output logic [31:0] act_rd, output logic [31:0] exp_rd);
    @(negedge CLK);
    dbus.daddr = a; dbus.ddata_w = wd; dbus.MemRead = rd; dbus.MemWrite = wr;
    #1;
    act_rd = dbus.ddata_r;
    exp_rd = model_read(a, rd);
    @(posedge CLK);
    model_edge(a, wd, wr);
    #1;
    dbus.MemWrite = 1'b0;
  endtask

  task automatic step_chk(input string name, input logic [31:0] a, input logic [31:0] wd,
                          input bit rd, input bit wr);
    logic [31:0] act, exp;
    bus(a, wd, rd, wr, act, exp);
    if (rd) chk({name, "_rd"}, act, exp);
    chk({name, "_gpio"}, gpio_out, m_gpio);
    chk({name, "_irq"}, {31'h0, irq}, {31'h0, m_pend});
  endtask

  task automatic reset_pulse();
    #2 RESET_N = 1'b0;
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    bit          rd;
    bit          wr;
    logic [31:0] exp_rd;
    logic [31:0] exp_gpio;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] act, exp, r, a, wd;
    logic [7:0]  offs [7];
    logic [7:0]  off;
    bit          rd, wr;
    int          c;

    offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C;
    offs[4] = 8'h10; offs[5] = 8'h14; offs[6] = 8'h40;

    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 32'h0,         32'h0};
    vecs[1]  = '{32'h0000_0010, 32'h0,         1, 0, 32'hDEAD_BEEF, 32'h0};
    vecs[2]  = '{32'h0000_0013, 32'h0,         1, 0, 32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{32'h0000_0010, 32'h0,         0, 0, 32'h0,         32'h0};
    vecs[4]  = '{32'h0000_1010, 32'h0,         1, 0, 32'hDEAD_BEEF, 32'h0};
    vecs[5]  = '{32'h1000_0000, 32'h0000_00A5, 0, 1, 32'h0,         32'hA5};
    vecs[6]  = '{32'h2000_0000, 32'h0000_1111, 0, 1, 32'h0,         32'hA5};
    vecs[7]  = '{32'h2000_0000, 32'h0,         1, 0, 32'h0,         32'hA5};
    vecs[8]  = '{32'h1000_0000, 32'h0,         1, 0, 32'hA5,        32'hA5};
    vecs[9]  = '{32'h1000_0020, 32'h0,         1, 0, 32'h0,         32'hA5};
    vecs[10] = '{32'h0000_0010, 32'h0000_1234, 1, 1, 32'hDEAD_BEEF, 32'hA5};
    vecs[11] = '{32'h0000_0010, 32'h0,         1, 0, 32'h0000_1234, 32'hA5};
    vecs[12] = '{32'h0000_1013, 32'h0,         1, 0, 32'h0000_1234, 32'hA5};
    vecs[13] = '{32'h1000_0003, 32'h0000_003C, 1, 1, 32'hA5,        32'h3C};

    RESET_N = 1'b0;
    dbus.daddr = 0; dbus.ddata_w = 0; dbus.MemRead = 0; dbus.MemWrite = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    chk("reset_gpio", gpio_out, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].wr, act, exp);
      chk($sformatf("vec%0d_rd", i), act, vecs[i].exp_rd);
      chk($sformatf("vec%0d_gpio", i), gpio_out, vecs[i].exp_gpio);
    end

    // Reset asserted mid-cycle with a RAM write pending.
    step_chk("gpio_pre_rst", 32'h1000_0000, 32'h0000_5A5A, 0, 1);
    #2 RESET_N = 1'b0;
    dbus.daddr = 32'h0000_0010; dbus.ddata_w = 32'hBAD0_BAD0; dbus.MemWrite = 1'b1;
    #1;
    chk("async_rst_gpio", gpio_out, 32'h0);
    chk("async_rst_irq", {31'h0, irq}, 32'h0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    dbus.MemWrite = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step_chk("idle", 32'h0, 32'h0, 0, 0);
    bus(32'h1000_0004, 32'h0, 1, 0, act, exp);
    chk("cycle_after_3", act, 32'd3);
    bus(32'h0000_0010, 32'h0, 1, 0, act, exp);
    chk("ram_write_dropped_in_rst", act, 32'h0000_1234);

    step_chk("cycle_write", 32'h1000_0004, 32'h0000_0000, 0, 1);
    step_chk("cycle_read", 32'h1000_0004, 32'h0, 1, 0);

    // Timer match, W1C, same-edge set vs clear, disable holds pending.
    reset_pulse();
    step_chk("cmp_wr", 32'h1000_0008, 32'd20, 0, 1);
    step_chk("ctrl_wr", 32'h1000_0010, 32'd1, 0, 1);
    while (m_cycle < 24) begin
      step_chk("tmr_idle", 32'h0, 32'h0, 0, 0);
      chk($sformatf("irq_at_cycle%0d", m_cycle), {31'h0, irq}, {31'h0, TIMER_EN && (m_cycle >= 21)});
    end
    bus(32'h1000_0008, 32'h0, 1, 0, act, exp);
    chk("cmp_read", act, TIMER_EN ? 32'd20 : 32'd0);
    step_chk("w1c", 32'h1000_000C, 32'd1, 0, 1);
    chk("irq_after_w1c", {31'h0, irq}, 32'h0);
    c = int'(m_cycle);
    step_chk("cmp_wr2", 32'h1000_0008, 32'(c + 2), 0, 1);
    step_chk("tmr_idle2", 32'h0, 32'h0, 0, 0);
    step_chk("w1c_same_edge", 32'h1000_000C, 32'd1, 0, 1);
    chk("irq_set_wins", {31'h0, irq}, {31'h0, TIMER_EN});
    step_chk("ctrl_off", 32'h1000_0010, 32'd0, 0, 1);
    chk("irq_held_disabled", {31'h0, irq}, {31'h0, TIMER_EN});
    step_chk("w1c2", 32'h1000_000C, 32'd1, 0, 1);
    step_chk("cmp_wr3", 32'h1000_0008, m_cycle + 32'd2, 0, 1);
    for (int i = 0; i < 4; i++) step_chk("disabled_idle", 32'h0, 32'h0, 0, 0);
    chk("irq_no_set_disabled", {31'h0, irq}, 32'h0);

    // Counter wrap.
    #1 force dut.u_regs.cycle = 32'hFFFF_FFFE;
    #1 release dut.u_regs.cycle;
    m_cycle = 32'hFFFF_FFFE;
    step_chk("wrap0", 32'h1000_0004, 32'h0, 1, 0);
    bus(32'h1000_0004, 32'h0, 1, 0, act, exp);
    chk("wrap_ffffffff", act, 32'hFFFF_FFFF);
    bus(32'h1000_0004, 32'h0, 1, 0, act, exp);
    chk("wrap_zero", act, 32'h0);

    // Random traffic against the reference model.
    for (int i = 0; i < 16; i++) step_chk("ram_init", 32'(i * 4), $urandom, 0, 1);
    for (int i = 0; i < 400; i++) begin
      r  = $urandom;
      wd = $urandom;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0, 1: a = {4'h0, r[27:12], 6'b0, 4'($urandom_range(0, 15)), r[1:0]};
        2: begin
          off = offs[$urandom_range(0, 6)];
          a = {4'h1, r[27:8], off[7:2], r[1:0]};
          if (off == 8'h08) wd = m_cycle + 32'($urandom_range(1, 4));
          if (off == 8'h10) wd = {31'h0, 1'($urandom_range(0, 1))};
        end
        default: a = {4'($urandom_range(2, 15)), r[27:0]};
      endcase
      step_chk("rand", a, wd, rd, wr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
